// File: rtl/wd_pkg.sv
// rtl/wd_pkg.sv - shared key-link constants and transmitter state encoding
package wd_pkg;

    localparam int KEY_BITS = 64;
    localparam int DNA_BITS = 57;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_END  = 2'd3
    } state_t;

endpackage

// File: rtl/wd_key_tx_bit_tick.sv
// rtl/wd_key_tx_bit_tick.sv - loadable down-counter marking the end of each sclk half-period
module bit_tick #(
    parameter int HALF_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic phase_end
);

    localparam int CW = $clog2(HALF_BIT) + 1;

    logic [CW-1:0] cnt;

    // Parks at zero between frames; each phase reloads on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(HALF_BIT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/wd_key_tx.sv
// rtl/wd_key_tx.sv - periodic serializer of the 64-bit watchdog key onto sclk/sdat/en
module wd_key_tx
    import wd_pkg::*;
#(
    parameter int HALF_BIT      = 4,
    parameter int PERIOD_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                auto_en,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                sclk,
    output logic                sdat,
    output logic                en,
    output logic                busy,
    output logic                done
);

    localparam int PW = $clog2(PERIOD_CYCLES);

    state_t              state;
    logic [PW-1:0]       period_cnt;
    logic                tick;
    logic                trig_q;
    logic                pending;
    logic                go;
    logic                load;
    logic                phase_end;
    logic [KEY_BITS-1:0] shreg;
    logic [5:0]          bit_cnt;

    assign tick = auto_en && (period_cnt == PW'(PERIOD_CYCLES - 1));
    assign go   = trig_q || pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (!auto_en || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    // Reload the half-period counter on every entry into LOW or HIGH.
    always_comb begin
        load = 1'b0;
        case (state)
            S_IDLE, S_END:  load = go;
            S_LOW, S_HIGH:  load = phase_end;
            default:        load = 1'b0;
        endcase
    end

    bit_tick #(.HALF_BIT(HALF_BIT)) u_bit_tick (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            trig_q  <= 1'b0;
            pending <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            sdat    <= 1'b0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            trig_q <= start || tick;
            done   <= 1'b0;
            case (state)
                S_IDLE, S_END: begin
                    if (go) begin
                        shreg   <= key;
                        bit_cnt <= 6'(KEY_BITS - 1);
                        sdat    <= key[KEY_BITS-1];
                        en      <= 1'b1;
                        sclk    <= 1'b0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                        state   <= S_LOW;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOW: begin
                    if (trig_q) pending <= 1'b1;
                    if (phase_end) begin
                        sclk  <= 1'b1;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (trig_q) pending <= 1'b1;
                    if (phase_end) begin
                        sclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            en    <= 1'b0;
                            sdat  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_END;
                        end else begin
                            // Next bit goes out on the same edge sclk falls.
                            shreg   <= shreg << 1;
                            sdat    <= shreg[KEY_BITS-2];
                            bit_cnt <= bit_cnt - 6'd1;
                            state   <= S_LOW;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wd_key_tx.sv
// tb/tb_wd_key_tx.sv - randomized self-checking bench for wd_key_tx with a behavioural receiver
module tb_wd_key_tx;

    localparam int HB  = 2;
    localparam int PER = 600;
    localparam int FRAME_CYC = 128 * HB;

    logic        clk;
    logic        rst;
    logic        auto_en;
    logic        start;
    logic [63:0] key;
    logic        sclk;
    logic        sdat;
    logic        en;
    logic        busy;
    logic        done;

    int total;
    int bad;

    logic [63:0] rx;
    int          rise_cnt;
    int          viol;
    logic        sclk_q, en_q, sdat_q;

    wd_key_tx #(.HALF_BIT(HB), .PERIOD_CYCLES(PER)) dut (
        .clk     (clk),
        .rst     (rst),
        .auto_en (auto_en),
        .start   (start),
        .key     (key),
        .sclk    (sclk),
        .sdat    (sdat),
        .en      (en),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver: shifts sdat into bit 0 on every sclk rise while en is high.
    initial begin
        rx = '0;
        rise_cnt = 0;
    end
    always @(posedge sclk) begin
        rise_cnt = rise_cnt + 1;
        if (en) rx = {rx[62:0], sdat};
    end

    // Link-protocol watch: at an sclk rise en must be high and sdat/en unchanged.
    initial begin
        viol = 0;
        sclk_q = 1'b0;
        en_q = 1'b0;
        sdat_q = 1'b0;
    end
    always @(negedge clk) begin
        if (!rst && sclk === 1'b1 && sclk_q === 1'b0) begin
            if (en !== 1'b1 || en !== en_q || sdat !== sdat_q) begin
                viol = viol + 1;
                $display("monitor: protocol violation at sclk rise, time %0t", $time);
            end
        end
        sclk_q = sclk;
        en_q = en;
        sdat_q = sdat;
    end

    task automatic run_frame(input logic [63:0] k, input bit mutate,
                             output int blen, output int first_rise, output int nrise,
                             output bit first_ok, output logic done_end, output logic done_after);
        int r0;
        @(negedge clk);
        key = k;
        start = 1'b1;
        r0 = rise_cnt;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        first_ok = (en === 1'b1 && busy === 1'b1 && sdat === k[63]);
        blen = 0;
        first_rise = -1;
        while (busy === 1'b1 && blen < 1000) begin
            if (sclk === 1'b1 && first_rise < 0) first_rise = blen;
            blen++;
            if (mutate && blen == 100) key = '1;
            @(negedge clk);
        end
        done_end = done;
        nrise = rise_cnt - r0;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        auto_en = 1'b0;
        start = 1'b0;
        key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        total++; if (sdat !== 1'b0) begin bad++; $display("FAIL reset_sdat: got %b want 0", sdat); end
        total++; if (en   !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_single_frame(input logic [63:0] k);
        int blen, fr, nr;
        bit fok;
        logic de, da;
        run_frame(k, 1'b0, blen, fr, nr, fok, de, da);
        total++; if (!fok) begin bad++; $display("FAIL frame_first_bit: en=%b busy=%b sdat=%b want 1 1 %b", en, busy, sdat, k[63]); end
        total++; if (blen != FRAME_CYC) begin bad++; $display("FAIL frame_busy_len: got %0d want %0d", blen, FRAME_CYC); end
        total++; if (fr != HB) begin bad++; $display("FAIL frame_first_rise: got %0d want %0d", fr, HB); end
        total++; if (nr != 64) begin bad++; $display("FAIL frame_rises: got %0d want 64", nr); end
        total++; if (rx !== k) begin bad++; $display("FAIL frame_capture: got %h want %h", rx, k); end
        total++; if (de !== 1'b1) begin bad++; $display("FAIL frame_done: got %b want 1", de); end
        total++; if (da !== 1'b0) begin bad++; $display("FAIL frame_done_width: got %b want 0", da); end
    endtask

    task automatic test_key_change(input logic [63:0] k);
        int blen, fr, nr;
        bit fok;
        logic de, da;
        run_frame(k, 1'b1, blen, fr, nr, fok, de, da);
        total++; if (rx !== k) begin bad++; $display("FAIL keychg_capture: got %h want %h", rx, k); end
        total++; if (blen != FRAME_CYC) begin bad++; $display("FAIL keychg_busy_len: got %0d want %0d", blen, FRAME_CYC); end
    endtask

    task automatic test_auto(input logic [63:0] k);
        int t[3];
        int n, cyc, r0;
        logic prev;
        key = k;
        r0 = rise_cnt;
        @(negedge clk);
        auto_en = 1'b1;
        n = 0;
        cyc = 0;
        prev = busy;
        while (n < 3 && cyc < 2500) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1 && prev !== 1'b1) begin
                t[n] = cyc;
                n++;
            end
            prev = busy;
        end
        auto_en = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        total++; if (n != 3) begin bad++; $display("FAIL auto_frames: got %0d want 3", n); end
        else begin
            total++; if (t[1] - t[0] != PER) begin bad++; $display("FAIL auto_interval1: got %0d want %0d", t[1] - t[0], PER); end
            total++; if (t[2] - t[1] != PER) begin bad++; $display("FAIL auto_interval2: got %0d want %0d", t[2] - t[1], PER); end
        end
        total++; if (rise_cnt - r0 != 192) begin bad++; $display("FAIL auto_rises: got %0d want 192", rise_cnt - r0); end
        total++; if (rx !== k) begin bad++; $display("FAIL auto_capture: got %h want %h", rx, k); end
    endtask

    task automatic test_back_to_back(input logic [63:0] k);
        int blen, blen2, idle_busy, r0;
        logic en_next, busy_next;
        r0 = rise_cnt;
        @(negedge clk);
        key = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        blen = 0;
        while (busy === 1'b1 && blen < 1000) begin
            blen++;
            start = (blen == 20 || blen == 90 || blen == 200);
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
        @(negedge clk);
        en_next = en;
        busy_next = busy;
        total++; if (en_next !== 1'b1 || busy_next !== 1'b1) begin bad++; $display("FAIL b2b_restart: en=%b busy=%b want 1 1", en_next, busy_next); end
        blen2 = 0;
        while (busy === 1'b1 && blen2 < 1000) begin
            blen2++;
            @(negedge clk);
        end
        total++; if (blen2 != FRAME_CYC) begin bad++; $display("FAIL b2b_busy_len: got %0d want %0d", blen2, FRAME_CYC); end
        idle_busy = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy === 1'b1) idle_busy++;
        end
        total++; if (idle_busy != 0) begin bad++; $display("FAIL b2b_extra_frame: busy cycles %0d want 0", idle_busy); end
        total++; if (rise_cnt - r0 != 128) begin bad++; $display("FAIL b2b_rises: got %0d want 128", rise_cnt - r0); end
        total++; if (rx !== k) begin bad++; $display("FAIL b2b_capture: got %h want %h", rx, k); end
    endtask

    task automatic test_reset_mid(input logic [63:0] k1, input logic [63:0] k2);
        int n, r0, blen, fr, nr;
        bit fok;
        logic de, da;
        r0 = rise_cnt;
        @(negedge clk);
        key = k1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rise_cnt - r0 < 30 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++; if (rise_cnt - r0 != 30) begin bad++; $display("FAIL rstmid_reach: rises %0d want 30", rise_cnt - r0); end
        rst = 1'b1;
        #1;
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
        total++; if (en   !== 1'b0) begin bad++; $display("FAIL rstmid_en: got %b want 0", en); end
        total++; if (sdat !== 1'b0) begin bad++; $display("FAIL rstmid_sdat: got %b want 0", sdat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0 || en !== 1'b0) begin bad++; $display("FAIL rstmid_idle: busy=%b en=%b want 0 0", busy, en); end
        run_frame(k2, 1'b0, blen, fr, nr, fok, de, da);
        total++; if (nr != 64) begin bad++; $display("FAIL rstmid_rises: got %0d want 64", nr); end
        total++; if (rx !== k2) begin bad++; $display("FAIL rstmid_capture: got %h want %h", rx, k2); end
        total++; if (blen != FRAME_CYC) begin bad++; $display("FAIL rstmid_busy_len: got %0d want %0d", blen, FRAME_CYC); end
    endtask

    task automatic test_protocol;
        total++; if (viol != 0) begin bad++; $display("FAIL protocol: violations %0d want 0", viol); end
    endtask

    function automatic logic [63:0] rand_key();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v;
    endfunction

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        auto_en = 1'b0;
        start = 1'b0;
        key = '0;
        test_reset();
        test_single_frame(64'h0123_4567_89AB_CDEF);
        test_single_frame(rand_key());
        test_key_change(64'h0123_4567_89AB_CDEF);
        test_auto(rand_key());
        test_back_to_back(rand_key());
        test_reset_mid(rand_key(), rand_key());
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wd_key_tx.md
# wd_key_tx

Serial key transmitter that feeds the watchdog's key shift register. It periodically serializes a 64-bit key (the device DNA in bits [56:0], zero-padded) onto a three-wire `sclk`/`sdat`/`en` link, so the watchdog sees a matching key before its timeout expires. It sits in the host-side logic on the system clock and drives the watchdog's `sclk`, `sdat` and `en` inputs directly.

## Interface
- `HALF_BIT`, default 4: `clk` cycles per `sclk` half-period; must be ≥1.
- `PERIOD_CYCLES`, default 50_000_000: auto-frame interval in `clk` cycles; must be > 128*`HALF_BIT`+2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `auto_en`  in  1  enables periodic frames.
- `start`  in  1  single-cycle request for an immediate frame.
- `key`  in  64  key to send; sampled only at frame start.
- `sclk`  out  1  serial clock to the receiver; data is valid at its rising edge.
- `sdat`  out  1  serial data, MSB first.
- `en`  out  1  shift enable; high only during frame bits.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- All outputs are registered. On reset, `sclk`, `sdat`, `en`, `busy`, `done`, the pending flag and the period counter are all 0, and the state is IDLE.
- Period counter: runs while `auto_en`=1. When it reaches `PERIOD_CYCLES`-1 it raises a tick and wraps to 0. It is cleared while `auto_en`=0.
- Trigger: `start`=1, or a tick.
  - A trigger in IDLE starts a frame.
  - A trigger while busy sets `pending`. A frame starts in the cycle after `done`, and that start clears `pending`.
  - Multiple triggers collapse into a single pending request.
- States:
  - IDLE → LOW on trigger. On this transition: `shreg`←`key`, `bit_cnt`←63, `sdat`←`key[63]`, `en`←1, `sclk`←0, `busy`←1.
  - LOW: hold `HALF_BIT` cycles, then → HIGH with `sclk`←1.
  - HIGH: hold `HALF_BIT` cycles. At the end:
    - if `bit_cnt`=0 → END;
    - else shift `shreg` left, `bit_cnt`−1, `sdat`←new `shreg[63]`, `sclk`←0, → LOW.
  - END (1 cycle): `sclk`=0, `en`=0, `sdat`=0, `done`=1, `busy`=0. Next state is LOW if `pending` is set, else IDLE.
- `sdat` and `en` change only while `sclk` is low, or on the same edge that `sclk` falls. They never change on a rising `sclk`.
- The receiver shifts `sdat` into bit 0 on each `sclk` rise while `en`=1. After 64 rises its register equals `key`.
- Exactly 64 `sclk` rises occur per frame. `sclk` never rises while `en`=0.
- `key` changes during a frame have no effect.
- Reset mid-frame: all outputs drop to 0 asynchronously. The partial frame is abandoned; the next full frame overwrites the receiver register.
- Phase hold counter width is clog2(`HALF_BIT`)+1; period counter width is clog2(`PERIOD_CYCLES`).

## Timing
- Trigger sampled at edge T. The first outputs (`en`=1, `busy`=1, `sdat`=`key[63]`) appear after edge T+1.
- First `sclk` rise is after edge T+1+`HALF_BIT`. Bit k (k=0 being `key[63]`) rises after edge T+1+(2k+1)·`HALF_BIT`.
- `busy` is high for exactly 128·`HALF_BIT` cycles. `done` is high for the single following cycle.
- Back-to-back frames from `pending`: the next frame's `en`=1 follows `done` by one cycle.
- Auto frame rate is one frame per `PERIOD_CYCLES` cycles when no `start` is used.

## Structure
- Shared package `wd_pkg`: `KEY_BITS`=64, `DNA_BITS`=57, the state enum (IDLE, LOW, HIGH, END). The receiver side uses the same constants.
- One sub-module, `bit_tick`: a loadable down-counter that emits the phase-end strobe every `HALF_BIT` cycles. The FSM and shift register stay in `wd_key_tx`.

## Test plan
- `HALF_BIT`=2, `key`=64'h0123_4567_89AB_CDEF, one `start` pulse → 64 `sclk` rises; a model shift register reads 64'h0123_4567_89AB_CDEF; `busy` lasts 256 cycles; a single `done` pulse follows.
- Same setup, `key` changed to all-ones mid-frame → captured value is still 64'h0123_4567_89AB_CDEF.
- `auto_en`=1, `PERIOD_CYCLES`=600, `HALF_BIT`=2 → frame starts 600 cycles apart; no `start` needed.
- `start` pulsed three times during a busy frame → exactly one extra frame; its `en` rises one cycle after `done`.
- `rst` asserted at bit 30 → `sclk`/`en`/`sdat`/`busy` are 0 in the same cycle; after release, IDLE; the next `start` yields a correct full 64-bit capture.
- Throughout all runs, an assertion checks: no `sclk` rise with `en`=0, and `sdat`/`en` never change on a rising `sclk`.
